// File: rtl/ctech_lib_clk_sw_ctrl.sv
// ----------------------------------------------------------------------------
// ctech_lib_clk_sw_ctrl
// Break-before-make controller for a two-source glitch-free clock switch.
// It drives the enables of the two clock gates that feed the NOR combiner.
// Both enables are held low for OFF_CYC cycles before the new source is
// enabled. The switch is reported complete ON_CYC cycles after that.
//
// Parameters:
//   OFF_CYC  cycles with both enables low before the new source (1..255)
//   ON_CYC   settle cycles after the new enable rises (1..255)
//   RST_SEL  source selected out of reset (0 = source 1, 1 = source 2)
//
// Ports:
//   clk      always-on control clock
//   rst      synchronous reset, active-high
//   sel_req  requested source (level, may change at any time)
//   en1      gate enable, source 1 (registered)
//   en2      gate enable, source 2 (registered)
//   sel_cur  currently committed source (registered)
//   busy     switch in progress (registered)
//   done     one-cycle pulse when a switch completes (registered)
//
// Optional feature, enabled by defining the macro CTECH_CLK_SW_CNT_EN:
//   sw_cnt   saturating count of completed switches (16 bits)
//   sw_abort one-cycle pulse when reset lands while a switch is in flight
// ----------------------------------------------------------------------------
module ctech_lib_clk_sw_ctrl #(
   parameter int unsigned OFF_CYC = 4,
   parameter int unsigned ON_CYC  = 2,
   parameter bit          RST_SEL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel_req,
   output logic        en1,
   output logic        en2,
   output logic        sel_cur,
   output logic        busy,
   output logic        done
`ifdef CTECH_CLK_SW_CNT_EN
   ,
   output logic [15:0] sw_cnt,
   output logic        sw_abort
`endif
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYC - 1);
   localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYC - 1);

   // Counter is 8 bits and must never wrap: reject out-of-range parameters.
   if (OFF_CYC < 1 || OFF_CYC > 255) begin : g_off_cyc_range
      $error("ctech_lib_clk_sw_ctrl: OFF_CYC must be in 1..255");
   end
   if (ON_CYC < 1 || ON_CYC > 255) begin : g_on_cyc_range
      $error("ctech_lib_clk_sw_ctrl: ON_CYC must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_STABLE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en1_q, en1_d;
   logic             en2_q, en2_d;
   logic             sel_cur_q, sel_cur_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_STABLE;
         cnt_q     <= '0;
         sel_cur_q <= RST_SEL;
         en1_q     <= ~RST_SEL;
         en2_q     <= RST_SEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sel_cur_q <= sel_cur_d;
         en1_q     <= en1_d;
         en2_q     <= en2_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next state and drain/settle counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_STABLE: begin
            if (sel_req != sel_cur_q) begin
               state_d = ST_DRAIN;
               cnt_d   = OFF_LOAD;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = ON_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs follow the state being entered; the target source is
   // always !sel_cur, and sel_cur only commits on the SETTLE->STABLE edge.
   always_comb begin
      sel_cur_d = sel_cur_q;
      en1_d     = 1'b0;
      en2_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      unique case (state_d)
         ST_STABLE: begin
            if (state_q == ST_SETTLE) begin
               sel_cur_d = ~sel_cur_q;
               done_d    = 1'b1;
            end
            en1_d = ~sel_cur_d;
            en2_d = sel_cur_d;
         end
         ST_DRAIN: begin
            busy_d = 1'b1;
         end
         ST_SETTLE: begin
            busy_d = 1'b1;
            en1_d  = sel_cur_q;
            en2_d  = ~sel_cur_q;
         end
         default: begin
            en1_d = ~sel_cur_q;
            en2_d = sel_cur_q;
         end
      endcase
   end

   assign en1     = en1_q;
   assign en2     = en2_q;
   assign sel_cur = sel_cur_q;
   assign busy    = busy_q;
   assign done    = done_q;

`ifdef CTECH_CLK_SW_CNT_EN
   logic [15:0] sw_cnt_q, sw_cnt_d;
   logic        sw_abort_q, sw_abort_d;

   // Saturating completion counter; abort flags a reset that cuts a switch.
   always_comb begin
      sw_cnt_d   = sw_cnt_q;
      sw_abort_d = rst & busy_q;
      if (done_d && (sw_cnt_q != 16'hFFFF)) begin
         sw_cnt_d = sw_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      sw_abort_q <= sw_abort_d;
      if (rst) begin
         sw_cnt_q <= '0;
      end else begin
         sw_cnt_q <= sw_cnt_d;
      end
   end

   assign sw_cnt   = sw_cnt_q;
   assign sw_abort = sw_abort_q;
`endif

endmodule

// File: tb/tb_ctech_lib_clk_sw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ctech_lib_clk_sw_ctrl
// Self-checking bench for ctech_lib_clk_sw_ctrl (OFF_CYC=4, ON_CYC=2,
// RST_SEL=0): a fixed vector table, hand-written corner sequences, and a
// randomized run checked against a timeline model of the switch.
// ----------------------------------------------------------------------------
module tb_ctech_lib_clk_sw_ctrl;

   localparam int unsigned OFF = 4;
   localparam int unsigned ON  = 2;
   localparam bit          RSEL = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel_req = 1'b0;
   logic en1, en2, sel_cur, busy, done;
`ifdef CTECH_CLK_SW_CNT_EN
   logic [15:0] sw_cnt;
   logic        sw_abort;
`endif

   ctech_lib_clk_sw_ctrl #(.OFF_CYC(OFF), .ON_CYC(ON), .RST_SEL(RSEL)) dut (
      .clk     (clk),
      .rst     (rst),
      .sel_req (sel_req),
      .en1     (en1),
      .en2     (en2),
      .sel_cur (sel_cur),
      .busy    (busy),
      .done    (done)
`ifdef CTECH_CLK_SW_CNT_EN
      ,
      .sw_cnt  (sw_cnt),
      .sw_abort(sw_abort)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Overlap of the two enables must never happen in any cycle.
   always @(negedge clk) begin
      if (mon_on) begin
         total++;
         if (en1 === 1'b1 && en2 === 1'b1) begin
            bad++;
            $display("FAIL no_overlap: en1=%b en2=%b expected not both 1 (t=%0t)", en1, en2, $time);
         end
      end
   end

   // Timeline model: a switch is a window starting at the launch edge; all
   // outputs follow from the elapsed edge count within that window.
   int   k = 0;
   bit   m_act = 1'b0;
   int   m_start = 0;
   logic m_cur = RSEL;
   logic m_tgt = 1'b0;
   logic e_en1 = 1'b1, e_en2 = 1'b0, e_cur = RSEL, e_busy = 1'b0, e_done = 1'b0;
   logic [15:0] m_cnt = '0;
   logic e_abort = 1'b0;

   task automatic model_edge(input logic r, input logic s);
      int el;
      k++;
      e_done  = 1'b0;
      e_abort = 1'b0;
      if (r) begin
         e_abort = e_busy;
         m_cur = RSEL;
         m_act = 1'b0;
         m_cnt = '0;
      end else if (m_act) begin
         if (k - m_start == int'(OFF + ON)) begin
            m_cur  = m_tgt;
            m_act  = 1'b0;
            e_done = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
      end else if (s != m_cur) begin
         m_act   = 1'b1;
         m_start = k;
         m_tgt   = ~m_cur;
      end
      e_cur = m_cur;
      if (m_act) begin
         el     = k - m_start;
         e_busy = 1'b1;
         e_en1  = (el >= int'(OFF)) && (m_tgt == 1'b0);
         e_en2  = (el >= int'(OFF)) && (m_tgt == 1'b1);
      end else begin
         e_busy = 1'b0;
         e_en1  = ~m_cur;
         e_en2  = m_cur;
      end
   endtask

   // Drive inputs mid-cycle, sample outputs just after the next active edge.
   task automatic step(input logic r, input logic s);
      @(negedge clk);
      rst = r;
      sel_req = s;
      @(posedge clk);
      #1;
      model_edge(r, s);
   endtask

   typedef struct {
      logic       r;
      logic       s;
      logic [4:0] exp;   // {en1, en2, sel_cur, busy, done}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic s, input logic [4:0] e);
      vec_t v;
      v.r = r; v.s = s; v.exp = e;
      return v;
   endfunction

   initial begin
      int n;
      bit seen;

      // Reset, request during drain that flips back and forth, completion,
      // back-to-back switch launched right after done, reset mid-drain.
      tbl.push_back(mk(1, 0, 5'b10000));
      tbl.push_back(mk(0, 0, 5'b10000));
      tbl.push_back(mk(0, 0, 5'b10000));
      tbl.push_back(mk(0, 0, 5'b10000));
      tbl.push_back(mk(0, 1, 5'b00010));
      tbl.push_back(mk(0, 1, 5'b00010));
      tbl.push_back(mk(0, 0, 5'b00010));
      tbl.push_back(mk(0, 1, 5'b00010));
      tbl.push_back(mk(0, 1, 5'b01010));
      tbl.push_back(mk(0, 1, 5'b01010));
      tbl.push_back(mk(0, 1, 5'b01101));
      tbl.push_back(mk(0, 1, 5'b01100));
      tbl.push_back(mk(0, 1, 5'b01100));
      tbl.push_back(mk(0, 0, 5'b00110));
      tbl.push_back(mk(0, 1, 5'b00110));
      tbl.push_back(mk(0, 1, 5'b00110));
      tbl.push_back(mk(0, 1, 5'b00110));
      tbl.push_back(mk(0, 1, 5'b10110));
      tbl.push_back(mk(0, 1, 5'b10110));
      tbl.push_back(mk(0, 1, 5'b10001));
      tbl.push_back(mk(0, 1, 5'b00010));
      tbl.push_back(mk(0, 1, 5'b00010));
      tbl.push_back(mk(1, 0, 5'b10000));
      tbl.push_back(mk(0, 0, 5'b10000));

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].s);
         mon_on = 1'b1;
         chk($sformatf("vec%0d", i), 32'({en1, en2, sel_cur, busy, done}), 32'(tbl[i].exp));
      end

      // Idle with sel_req matching: nothing moves for 20 cycles.
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(0, 0);
         if (done !== 1'b0 || busy !== 1'b0 || en1 !== 1'b1) seen = 1'b1;
      end
      chk("idle_quiet", 32'(seen), 32'd0);

      // One-cycle request glitch still launches a complete switch.
      step(0, 1);
      chk("glitch_busy", 32'(busy), 32'd1);
      n = 0;
      while (en2 !== 1'b1 && n < 20) begin
         step(0, 0);
         n++;
      end
      chk("glitch_en2_latency", 32'(n), 32'(OFF));
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         step(0, 0);
         n++;
      end
      chk("glitch_done_latency", 32'(n), 32'(ON));
      chk("glitch_sel_cur", 32'(sel_cur), 32'd1);
      step(0, 0);
      chk("glitch_done_width", 32'(done), 32'd0);
      chk("glitch_relaunch", 32'(busy), 32'd1);

      // Randomized run against the timeline model.
      step(1, 0);
      for (int i = 0; i < 800; i++) begin
         logic r, s;
         r = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 5) == 0) ? ~sel_req : sel_req;
         step(r, s);
         chk("rnd_en1", 32'(en1), 32'(e_en1));
         chk("rnd_en2", 32'(en2), 32'(e_en2));
         chk("rnd_sel_cur", 32'(sel_cur), 32'(e_cur));
         chk("rnd_busy", 32'(busy), 32'(e_busy));
         chk("rnd_done", 32'(done), 32'(e_done));
`ifdef CTECH_CLK_SW_CNT_EN
         chk("rnd_sw_cnt", 32'(sw_cnt), 32'(m_cnt));
         chk("rnd_sw_abort", 32'(sw_abort), 32'(e_abort));
`endif
      end

`ifdef CTECH_CLK_SW_CNT_EN
      // Three clean switches, then a reset while busy.
      step(1, 0);
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < int'(OFF + ON) + 2; i++) step(0, ~m_cur);
      end
      chk("cnt_three", 32'(sw_cnt), 32'(m_cnt));
      step(0, ~m_cur);
      step(1, 0);
      chk("abort_pulse", 32'(sw_abort), 32'd1);
      chk("abort_cnt_clr", 32'(sw_cnt), 32'd0);
      step(0, 0);
      chk("abort_once", 32'(sw_abort), 32'd0);
`endif

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
